// File: rtl/decimal_entry_pkg.sv
// Shared types and defaults for the decimal entry unit.
package decimal_entry_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEntry,
    StFull,
    StError
  } state_e;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam int unsigned MAX_DIGITS_DEF = 3;
  localparam int unsigned OUT_W_DEF      = 8;
  localparam int unsigned ACC_W_DEF      = 10;

endpackage

// File: rtl/decimal_entry.sv
// Decimal keypad entry: accumulates up to MAX_DIGITS decimal digits into a
// binary value, range-checks it on enter and delivers an OUT_W-bit operand.
// Optional feature: DECIMAL_ENTRY_BACKSPACE_EN adds the backspace port and
// the divide-by-10 path.
module decimal_entry
  import decimal_entry_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEF,
  parameter int unsigned OUT_W      = OUT_W_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             enter,
  input  logic             clear,
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
  input  logic             backspace,
`endif
  output logic [ACC_W-1:0] live_value,
  output logic [1:0]       digit_count,
  output logic [OUT_W-1:0] value_out,
  output logic             value_valid,
  output logic             overflow
);

  localparam logic [ACC_W-1:0] OutMax   = ACC_W'((1 << OUT_W) - 1);
  localparam logic [1:0]       CountMax = 2'(MAX_DIGITS);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]       count_q, count_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             bs_req;

`ifdef DECIMAL_ENTRY_BACKSPACE_EN
  assign bs_req = backspace;
`else
  assign bs_req = 1'b0;
`endif

  // Next-state: one event per cycle, clear > enter > backspace > digit.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    overflow_d = overflow_q;

    if (clear) begin
      state_d    = StIdle;
      acc_d      = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (enter) begin
      if (state_q == StEntry || state_q == StFull) begin
        if (acc_q <= OutMax) begin
          value_d = acc_q[OUT_W-1:0];
          valid_d = 1'b1;
          acc_d   = '0;
          count_d = '0;
          state_d = StIdle;
        end else begin
          state_d    = StError;
          overflow_d = 1'b1;
        end
      end
    end else if (bs_req) begin
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
      if (state_q == StEntry || state_q == StFull) begin
        acc_d   = acc_q / ACC_W'(10);
        count_d = count_q - 2'd1;
        state_d = (count_q == 2'd1) ? StIdle : StEntry;
      end
`endif
    end else if (digit_valid) begin
      if (digit <= DIGIT_MAX && (state_q == StIdle || state_q == StEntry)) begin
        acc_d   = acc_q * ACC_W'(10) + ACC_W'(digit);
        count_d = count_q + 2'd1;
        state_d = (count_q + 2'd1 == CountMax) ? StFull : StEntry;
      end
    end
  end

  // State and datapath registers; reset discards any pending entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      count_q    <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign live_value  = acc_q;
  assign digit_count = count_q;
  assign value_out   = value_q;
  assign value_valid = valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_decimal_entry.sv
// Directed scoreboard bench for decimal_entry.
module tb_decimal_entry;

  typedef struct {
    string      tag;
    logic [9:0] live;
    logic [1:0] count;
    logic [7:0] value;
    logic       valid;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       backspace = 1'b0;
  logic [9:0] live_value;
  logic [1:0] digit_count;
  logic [7:0] value_out;
  logic       value_valid;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  decimal_entry dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_valid (digit_valid),
    .digit       (digit),
    .enter       (enter),
    .clear       (clear),
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
    .backspace   (backspace),
`endif
    .live_value  (live_value),
    .digit_count (digit_count),
    .value_out   (value_out),
    .value_valid (value_valid),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [9:0] l, input logic [1:0] c,
                      input logic [7:0] v, input logic vv, input logic ov);
    exp_t e;
    e.tag = tag; e.live = l; e.count = c; e.value = v; e.valid = vv; e.ovf = ov;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the current outputs.
  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard empty");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "live", 16'(live_value), 16'(e.live));
    chk(e.tag, "count", 16'(digit_count), 16'(e.count));
    chk(e.tag, "value", 16'(value_out), 16'(e.value));
    chk(e.tag, "valid", 16'(value_valid), 16'(e.valid));
    chk(e.tag, "ovf", 16'(overflow), 16'(e.ovf));
  endtask

  // Drive one cycle of strobes, record expectation, sample after the edge.
  task automatic step(input string tag, input logic dv, input logic [3:0] d,
                      input logic en, input logic cl, input logic bs,
                      input logic [9:0] l, input logic [1:0] c, input logic [7:0] v,
                      input logic vv, input logic ov);
    @(negedge clk);
    digit_valid = dv; digit = d; enter = en; clear = cl; backspace = bs;
    push(tag, l, c, v, vv, ov);
    @(posedge clk);
    #1;
    digit_valid = 1'b0; enter = 1'b0; clear = 1'b0; backspace = 1'b0;
    pop_check();
  endtask

  task automatic dig(input string tag, input logic [3:0] d, input logic [9:0] l,
                     input logic [1:0] c, input logic [7:0] v, input logic ov);
    step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, l, c, v, 1'b0, ov);
  endtask

  initial begin
    #2;
    push("reset", 10'd0, 2'd0, 8'd0, 1'b0, 1'b0);
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;

    // 1,2,8 enter
    dig("d1", 4'd1, 10'd1, 2'd1, 8'd0, 1'b0);
    dig("d12", 4'd2, 10'd12, 2'd2, 8'd0, 1'b0);
    dig("d128", 4'd8, 10'd128, 2'd3, 8'd0, 1'b0);
    step("ent128", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 2'd0, 8'd128, 1'b1, 1'b0);
    step("post128", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd0, 8'd128, 1'b0, 1'b0);

    // 2,5,6 enter -> overflow, digit ignored, clear recovers
    dig("d2", 4'd2, 10'd2, 2'd1, 8'd128, 1'b0);
    dig("d25", 4'd5, 10'd25, 2'd2, 8'd128, 1'b0);
    dig("d256", 4'd6, 10'd256, 2'd3, 8'd128, 1'b0);
    step("ent256", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd256, 2'd3, 8'd128, 1'b0, 1'b1);
    dig("err_dig", 4'd3, 10'd256, 2'd3, 8'd128, 1'b1);
    step("err_ent", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd256, 2'd3, 8'd128, 1'b0, 1'b1);
    step("clr", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 10'd0, 2'd0, 8'd128, 1'b0, 1'b0);

    // 1,2,3,4: fourth ignored in FULL
    dig("f1", 4'd1, 10'd1, 2'd1, 8'd128, 1'b0);
    dig("f12", 4'd2, 10'd12, 2'd2, 8'd128, 1'b0);
    dig("f123", 4'd3, 10'd123, 2'd3, 8'd128, 1'b0);
    dig("f4th", 4'd4, 10'd123, 2'd3, 8'd128, 1'b0);
    step("ent123", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 2'd0, 8'd123, 1'b1, 1'b0);

    // Bad code and enter in IDLE
    dig("code12", 4'd12, 10'd0, 2'd0, 8'd123, 1'b0);
    step("ent_idle", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 2'd0, 8'd123, 1'b0, 1'b0);

    // Boundary 255 accepted; leading zeros count as digits
    dig("b2", 4'd2, 10'd2, 2'd1, 8'd123, 1'b0);
    dig("b25", 4'd5, 10'd25, 2'd2, 8'd123, 1'b0);
    dig("b255", 4'd5, 10'd255, 2'd3, 8'd123, 1'b0);
    step("ent255", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 2'd0, 8'd255, 1'b1, 1'b0);
    dig("z0", 4'd0, 10'd0, 2'd1, 8'd255, 1'b0);
    dig("z00", 4'd0, 10'd0, 2'd2, 8'd255, 1'b0);
    dig("z007", 4'd7, 10'd7, 2'd3, 8'd255, 1'b0);
    dig("z_full", 4'd1, 10'd7, 2'd3, 8'd255, 1'b0);
    step("ent007", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 2'd0, 8'd7, 1'b1, 1'b0);

    // Back-to-back short entries
    dig("bb5", 4'd5, 10'd5, 2'd1, 8'd7, 1'b0);
    step("ent5", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 2'd0, 8'd5, 1'b1, 1'b0);
    dig("bb6", 4'd6, 10'd6, 2'd1, 8'd5, 1'b0);
    step("ent6", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 2'd0, 8'd6, 1'b1, 1'b0);

    // Enter with a digit in the same cycle: digit dropped
    dig("ed4", 4'd4, 10'd4, 2'd1, 8'd6, 1'b0);
    step("ent_dig", 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 10'd0, 2'd0, 8'd4, 1'b1, 1'b0);

    // 4,2 then clear+enter together: clear wins
    dig("c4", 4'd4, 10'd4, 2'd1, 8'd4, 1'b0);
    dig("c42", 4'd2, 10'd42, 2'd2, 8'd4, 1'b0);
    step("clr_ent", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 10'd0, 2'd0, 8'd4, 1'b0, 1'b0);

`ifdef DECIMAL_ENTRY_BACKSPACE_EN
    dig("k9", 4'd9, 10'd9, 2'd1, 8'd4, 1'b0);
    dig("k98", 4'd8, 10'd98, 2'd2, 8'd4, 1'b0);
    step("bs98", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 10'd9, 2'd1, 8'd4, 1'b0, 1'b0);
    dig("k97", 4'd7, 10'd97, 2'd2, 8'd4, 1'b0);
    step("ent97", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 2'd0, 8'd97, 1'b1, 1'b0);
    step("bs_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 10'd0, 2'd0, 8'd97, 1'b0, 1'b0);
    dig("k3", 4'd3, 10'd3, 2'd1, 8'd97, 1'b0);
    step("bs_dig", 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 10'd0, 2'd0, 8'd97, 1'b0, 1'b0);
    dig("k1", 4'd1, 10'd1, 2'd1, 8'd97, 1'b0);
    step("ent1", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 2'd0, 8'd1, 1'b1, 1'b0);
`endif

    // Asynchronous reset mid-entry, checked before any clock edge
    dig("r7", 4'd7, 10'd7, 2'd1, value_exp_before_reset(), 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst", 10'd0, 2'd0, 8'd0, 1'b0, 1'b0);
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd0, 8'd0, 1'b0, 1'b0);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard residue=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Committed value expected just before the reset test, per build.
  function automatic logic [7:0] value_exp_before_reset();
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
    return 8'd1;
`else
    return 8'd4;
`endif
  endfunction

endmodule
